inc_req_seq: RTL and testbench
==============================

// Module: inc_req_seq
// PURPOSE
//  Upstream sequencer for the pulse-driven increment counters (the inc_test-style 2-bit counters).
//  Accepts a command (pulse count, inter-pulse gap) over valid/ready and drives a train of
//  single-cycle, glitch-free increment requests onto the counter's test_inc input.
//  Guarantees at least one low cycle between pulses so every request is a distinct rising edge.
// PARAMETERS
//  CNT_W  8  width of cmd_count / pulses_sent (max pulses per command = 2^CNT_W-1)
//  GAP_W  4  width of cmd_gap (idle cycles between pulses)
//  OUT_W  2  width of downstream counter mirrored by shadow_val
// PORTS
//  clk          in   1      system clock, all state on posedge
//  rst_n        in   1      asynchronous active-low reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      command accepted when cmd_valid && cmd_ready
//  cmd_count    in   CNT_W  number of increment pulses to emit
//  cmd_gap      in   GAP_W  low cycles between pulses (0 treated as 1)
//  abort        in   1      synchronous abort of the running command
//  inc_out      out  1      registered increment request, to downstream test_inc
//  busy         out  1      high while in PULSE or GAP
//  done         out  1      one-cycle strobe at end of command (normal or aborted)
//  pulses_sent  out  CNT_W  pulses emitted for the current/last command
//  shadow_val   out  OUT_W  expected downstream counter value (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE; inc_out, busy, done, pulses_sent, shadow_val = 0;
//   cmd_ready = (state==IDLE), so it reads 1 throughout reset and immediately after release.
//  FSM states: IDLE, PULSE, GAP, DONE.
//  IDLE: cmd_ready=1. On accept at edge k: latch count, gap_eff=max(cmd_gap,1); clear pulses_sent.
//   count!=0 -> PULSE (inc_out=1 in cycle k+1). count==0 -> DONE (done=1 in cycle k+1, no pulse).
//  PULSE: inc_out=1 for exactly one cycle; pulses_sent increments at the edge ending it.
//   Pulses remaining -> GAP; last pulse -> DONE (no trailing gap).
//  GAP: inc_out=0 for gap_eff cycles, then PULSE. Period between pulse starts = gap_eff+1.
//  DONE: done=1 one cycle, inc_out=0, then IDLE. cmd_ready=0 in DONE.
//  abort: priority over normal progress. In PULSE/GAP -> DONE next edge; a pulse already high
//   completes its single cycle and is counted. Abort in DONE or IDLE: no effect; abort together
//   with cmd_valid in IDLE -> command accepted normally.
//  pulses_sent holds its final value after done until the next accept; never wraps (count<=max).
//  Back-to-back: cmd_valid held high -> next command accepted in the IDLE cycle after DONE.
//  Reset mid-command: async return to IDLE, inc_out drops immediately, no done strobe.
//  All outputs except cmd_ready are registered; cmd_ready is decoded from the state register.
// CONFIGURATION
//  SHADOW_CNT_EN defined: shadow_val increments modulo 2^OUT_W at the edge ending each PULSE
//   cycle, cleared only by reset (not by commands); used by benches to check the downstream
//   counter. Not defined: shadow_val tied to 0; no shadow register.
// STRUCTURE
//  Package inc_seq_pkg: state enum (IDLE/PULSE/GAP/DONE, 2-bit encoding), default widths.
//  Sub-module inc_gap_timer: loadable GAP_W down-counter (load, dec, zero flag), used for GAP.
//  Everything else is flat in inc_req_seq.
// TESTING (CNT_W=8, GAP_W=4, OUT_W=2, SHADOW_CNT_EN defined; accept edge = cycle 0)
//  1 count=8 gap=1 -> inc_out high cycles 1,3,...,15; done cycle 16; cmd_ready cycle 17;
//    pulses_sent=8; shadow_val back to 0; downstream out returns to 0.
//  2 count=3 gap=0 -> behaves as gap=1: pulses cycles 1,3,5; done cycle 6.
//  3 count=0 gap=5 -> no inc_out pulse; done cycle 1; pulses_sent=0.
//  4 count=10 gap=2, abort asserted in cycle 8 (GAP after pulse 3) -> done cycle 9,
//    pulses_sent=3, shadow_val=3.
//  5 count=5 gap=3, rst_n low in cycle 6 -> inc_out 0 at once, no done strobe,
//    pulses_sent=0, state IDLE; new command after release runs normally.
//  6 cmd_valid held high with two commands (2,1) then (1,1) -> first done cycle 4,
//    second accepted cycle 5, its pulse cycle 6, done cycle 7.

Source files
------------

// File: rtl/inc_req_seq_pkg.sv
// Shared types and default widths for the increment-request sequencer.
package inc_seq_pkg;
   localparam int CNT_W_DEF = 8;
   localparam int GAP_W_DEF = 4;
   localparam int OUT_W_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;
endpackage

// File: rtl/inc_req_seq_if.sv
// Command handshake bundle: the upstream agent drives a (count, gap) command over valid/ready.
interface inc_req_seq_if #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_count;
   logic [GAP_W-1:0] cmd_gap;

   modport master (output cmd_valid, cmd_count, cmd_gap, input cmd_ready);
   modport slave  (input cmd_valid, cmd_count, cmd_gap, output cmd_ready);
endinterface

// File: rtl/inc_gap_timer.sv
// Loadable down-counter timing the low cycles between increment pulses.
module inc_gap_timer #(
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [GAP_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);
   logic [GAP_W-1:0] val_q, val_d;

   always_comb begin
      val_d = val_q;
      if (load)
         val_d = load_val;
      else if (dec && (val_q != '0))
         val_d = val_q - GAP_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) val_q <= '0;
      else        val_q <= val_d;
   end

   assign zero = (val_q == '0);
endmodule

// File: rtl/inc_req_seq.sv
// Sequencer emitting trains of single-cycle increment pulses separated by idle gaps.
// Optional shadow counter of the downstream value is enabled with SHADOW_CNT_EN.
module inc_req_seq
   import inc_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int GAP_W = GAP_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   inc_req_seq_if.slave     cmd,
   input  logic             abort,
   output logic             inc_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulses_sent,
   output logic [OUT_W-1:0] shadow_val
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [CNT_W-1:0] pulses_q, pulses_d, pulses_inc;
   logic             inc_q, inc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tmr_load, tmr_dec, tmr_zero;
   logic [GAP_W-1:0] tmr_val;
   logic             pulse_end;

   // Timer is loaded with gap-1 so the GAP state lasts exactly gap_eff cycles.
   inc_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   assign pulses_inc = pulses_q + CNT_W'(1);
   assign tmr_val    = gap_q - GAP_W'(1);
   assign pulse_end  = (state_q == ST_PULSE);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      gap_d    = gap_q;
      pulses_d = pulses_q;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd.cmd_valid) begin
               count_d  = cmd.cmd_count;
               gap_d    = (cmd.cmd_gap == '0) ? GAP_W'(1) : cmd.cmd_gap;
               pulses_d = '0;
               state_d  = (cmd.cmd_count != '0) ? ST_PULSE : ST_DONE;
            end
         end
         ST_PULSE: begin
            // A pulse already on the wire always completes and is counted, even on abort.
            pulses_d = pulses_inc;
            if (abort || (pulses_inc == count_q)) begin
               state_d = ST_DONE;
            end else begin
               state_d  = ST_GAP;
               tmr_load = 1'b1;
            end
         end
         ST_GAP: begin
            if (abort)
               state_d = ST_DONE;
            else if (tmr_zero)
               state_d = ST_PULSE;
            else
               tmr_dec = 1'b1;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      inc_d  = (state_d == ST_PULSE);
      busy_d = (state_d == ST_PULSE) || (state_d == ST_GAP);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         gap_q    <= '0;
         pulses_q <= '0;
         inc_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         gap_q    <= gap_d;
         pulses_q <= pulses_d;
         inc_q    <= inc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

`ifdef SHADOW_CNT_EN
   logic [OUT_W-1:0] shadow_q, shadow_d;

   // Tracks the downstream counter across commands; only reset clears it.
   always_comb begin
      shadow_d = shadow_q;
      if (pulse_end)
         shadow_d = shadow_q + OUT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shadow_q <= '0;
      else        shadow_q <= shadow_d;
   end

   assign shadow_val = shadow_q;
`else
   logic unused_pulse_end;
   assign unused_pulse_end = pulse_end;
   assign shadow_val       = '0;
`endif

   assign cmd.cmd_ready = (state_q == ST_IDLE);
   assign inc_out       = inc_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pulses_sent   = pulses_q;
endmodule

// File: tb/tb_inc_req_seq.sv
// Scoreboard bench for inc_req_seq: expected pulse/done cycles are queued per command.
module tb_inc_req_seq;
   localparam int CNT_W = 8;
   localparam int GAP_W = 4;
   localparam int OUT_W = 2;
   localparam int LIMIT = 400;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             abort = 1'b0;
   logic             inc_out, busy, done;
   logic [CNT_W-1:0] pulses_sent;
   logic [OUT_W-1:0] shadow_val;

   inc_req_seq_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) cif ();

   inc_req_seq #(.CNT_W(CNT_W), .GAP_W(GAP_W), .OUT_W(OUT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd         (cif.slave),
      .abort       (abort),
      .inc_out     (inc_out),
      .busy        (busy),
      .done        (done),
      .pulses_sent (pulses_sent),
      .shadow_val  (shadow_val)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pulse_q[$];
   int done_q[$];
   int sent_q[$];
   int shadow_model = 0;

   task automatic test_reset();
      cif.cmd_valid = 1'b0;
      cif.cmd_count = '0;
      cif.cmd_gap   = '0;
      rst_n = 1'b0;
      #12;
      checks++;
      if ({inc_out, busy, done} !== 3'b000 || pulses_sent !== '0 || shadow_val !== '0) begin
         errors++;
         $display("FAIL reset_outputs: inc/busy/done=%b sent=%0d shadow=%0d, want 000/0/0",
                  {inc_out, busy, done}, pulses_sent, shadow_val);
      end
      checks++;
      if (cif.cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", cif.cmd_ready);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cif.cmd_ready !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL post_reset: ready=%b done=%b want 1/0", cif.cmd_ready, done);
      end
   endtask

   // abort_at: cycle in which abort is high (0 = together with the command, <0 = never).
   // rst_at:   cycle in which rst_n is pulled low (<0 = never).
   task automatic run_cmd(input string name, input int cnt, input int gap,
                          input int abort_at, input int rst_at);
      int g, t, n, normal_done, exp;
      bit finished;
      g = (gap == 0) ? 1 : gap;
      pulse_q.delete(); done_q.delete(); sent_q.delete();
      for (int i = 0; i < cnt; i++) begin
         t = 1 + i * (g + 1);
         if ((abort_at < 1 || t <= abort_at) && (rst_at < 0 || t < rst_at)) pulse_q.push_back(t);
      end
      normal_done = (cnt == 0) ? 1 : (1 + (cnt - 1) * (g + 1) + 1);
      if (rst_at < 0) begin
         done_q.push_back((abort_at >= 1 && abort_at < normal_done) ? abort_at + 1 : normal_done);
         sent_q.push_back(pulse_q.size());
      end

      @(negedge clk);
      checks++;
      if (cif.cmd_ready !== 1'b1) begin
         errors++; $display("FAIL %s ready_before: got %b want 1", name, cif.cmd_ready);
      end
      cif.cmd_valid = 1'b1;
      cif.cmd_count = CNT_W'(cnt);
      cif.cmd_gap   = GAP_W'(gap);
      abort = (abort_at == 0);
      n = 0;
      finished = 1'b0;
      while (!finished && n < LIMIT) begin
         @(negedge clk);
         n++;
         cif.cmd_valid = 1'b0;
         if (inc_out === 1'b1) begin
            checks++;
            if (pulse_q.size() == 0) begin
               errors++; $display("FAIL %s pulse: unexpected pulse at cycle %0d", name, n);
            end else begin
               exp = pulse_q.pop_front();
               if (n !== exp) begin
                  errors++; $display("FAIL %s pulse_cycle: got %0d want %0d", name, n, exp);
               end
            end
            checks++;
            if (busy !== 1'b1 || shadow_val !== OUT_W'(shadow_model)) begin
               errors++; $display("FAIL %s pulse_state: busy=%b shadow=%0d want 1/%0d",
                                  name, busy, shadow_val, shadow_model);
            end
`ifdef SHADOW_CNT_EN
            shadow_model = (shadow_model + 1) % (1 << OUT_W);
`endif
         end
         if (done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++; $display("FAIL %s done: unexpected strobe at cycle %0d", name, n);
            end else begin
               exp = done_q.pop_front();
               if (n !== exp) begin
                  errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, n, exp);
               end
               exp = sent_q.pop_front();
               checks++;
               if (pulses_sent !== CNT_W'(exp)) begin
                  errors++; $display("FAIL %s pulses_sent: got %0d want %0d", name, pulses_sent, exp);
               end
            end
            checks++;
            if ({cif.cmd_ready, busy, inc_out} !== 3'b000 || shadow_val !== OUT_W'(shadow_model)) begin
               errors++; $display("FAIL %s done_state: ready/busy/inc=%b shadow=%0d want 000/%0d",
                                  name, {cif.cmd_ready, busy, inc_out}, shadow_val, shadow_model);
            end
            @(negedge clk);
            checks++;
            if (cif.cmd_ready !== 1'b1 || done !== 1'b0 || pulses_sent !== CNT_W'(exp)) begin
               errors++; $display("FAIL %s after_done: ready=%b done=%b sent=%0d want 1/0/%0d",
                                  name, cif.cmd_ready, done, pulses_sent, exp);
            end
            finished = 1'b1;
         end
         abort = (n == abort_at);
         if (!finished && n == rst_at) begin
            rst_n = 1'b0;
            abort = 1'b0;
            #1;
            checks++;
            if ({inc_out, busy, done} !== 3'b000 || pulses_sent !== '0 ||
                shadow_val !== '0 || cif.cmd_ready !== 1'b1) begin
               errors++; $display("FAIL %s mid_reset: inc/busy/done=%b sent=%0d shadow=%0d ready=%b",
                                  name, {inc_out, busy, done}, pulses_sent, shadow_val, cif.cmd_ready);
            end
            shadow_model = 0;
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || inc_out !== 1'b0) begin
               errors++; $display("FAIL %s reset_hold: done=%b inc=%b want 0/0", name, done, inc_out);
            end
            rst_n = 1'b1;
            @(negedge clk);
            finished = 1'b1;
         end
      end
      abort = 1'b0;
      checks++;
      if (!finished || pulse_q.size() != 0 || done_q.size() != 0) begin
         errors++; $display("FAIL %s completion: finished=%b pulses_left=%0d dones_left=%0d",
                            name, finished, pulse_q.size(), done_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int n, exp, dn;
      pulse_q = '{1, 3, 6};
      done_q  = '{4, 7};
      sent_q  = '{2, 1};
      @(negedge clk);
      cif.cmd_valid = 1'b1;
      cif.cmd_count = CNT_W'(2);
      cif.cmd_gap   = GAP_W'(1);
      n = 0; dn = 0;
      while (dn < 2 && n < LIMIT) begin
         @(negedge clk);
         n++;
         if (inc_out === 1'b1) begin
            checks++;
            exp = (pulse_q.size() != 0) ? pulse_q.pop_front() : -1;
            if (n !== exp) begin
               errors++; $display("FAIL b2b pulse_cycle: got %0d want %0d", n, exp);
            end
`ifdef SHADOW_CNT_EN
            shadow_model = (shadow_model + 1) % (1 << OUT_W);
`endif
         end
         if (done === 1'b1) begin
            checks++;
            exp = (done_q.size() != 0) ? done_q.pop_front() : -1;
            if (n !== exp) begin
               errors++; $display("FAIL b2b done_cycle: got %0d want %0d", n, exp);
            end
            exp = (sent_q.size() != 0) ? sent_q.pop_front() : -1;
            checks++;
            if (pulses_sent !== CNT_W'(exp)) begin
               errors++; $display("FAIL b2b pulses_sent: got %0d want %0d", pulses_sent, exp);
            end
            dn++;
         end
         if (n == 2) begin
            checks++;
            if (cif.cmd_ready !== 1'b0) begin
               errors++; $display("FAIL b2b ready_busy: got %b want 0", cif.cmd_ready);
            end
         end
         if (n == 4) begin
            cif.cmd_count = CNT_W'(1);
            cif.cmd_gap   = GAP_W'(1);
         end
         if (n == 5) begin
            checks++;
            if (cif.cmd_ready !== 1'b1) begin
               errors++; $display("FAIL b2b ready_accept: got %b want 1", cif.cmd_ready);
            end
         end
         if (n == 6) cif.cmd_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (dn != 2 || pulse_q.size() != 0 || cif.cmd_ready !== 1'b1 ||
          shadow_val !== OUT_W'(shadow_model)) begin
         errors++; $display("FAIL b2b completion: dones=%0d pulses_left=%0d ready=%b shadow=%0d want 2/0/1/%0d",
                            dn, pulse_q.size(), cif.cmd_ready, shadow_val, shadow_model);
      end
   endtask

   initial begin
      test_reset();
      run_cmd("basic_8x1",     8, 1, -1, -1);
      run_cmd("gap_zero",      3, 0, -1, -1);
      run_cmd("zero_count",    0, 5, -1, -1);
      run_cmd("abort_gap",    10, 2,  8, -1);
      run_cmd("abort_pulse",   4, 2,  4, -1);
      run_cmd("abort_idle",    2, 1,  0, -1);
      run_cmd("reset_mid",     5, 3, -1,  6);
      run_cmd("after_reset",   2, 2, -1, -1);
      run_cmd("wide_gap",      2, 15, -1, -1);
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
